// File: rtl/fnn_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fnn_pkg
// Brief    : Shared types for the IIR coefficient loader (frame order, FSM).
// Revision : 1.0
// ============================================================================
package fnn_pkg;

    localparam int NUM_COEFFS = 9;

    // Frame order: the position in this enum is the coefficient's slot in a frame.
    typedef enum logic [3:0] {
        B0 = 4'd0,
        B1 = 4'd1,
        B2 = 4'd2,
        B3 = 4'd3,
        B4 = 4'd4,
        B5 = 4'd5,
        B6 = 4'd6,
        A3 = 4'd7,
        A6 = 4'd8
    } coeff_idx_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_SWAP = 2'd2
    } loader_state_e;

endpackage
`default_nettype wire

// File: rtl/coeff_bank.sv
`default_nettype none
// ============================================================================
// Module   : coeff_bank
// Brief    : Shadow bank of NUM_COEFFS coefficients with per-word write enable.
// Revision : 1.0
// ============================================================================
module coeff_bank
    import fnn_pkg::*;
#(
    parameter int WIDTH    = 64,
    parameter int BUS_BITS = 16,
    localparam int C_WPC   = WIDTH / BUS_BITS,
    localparam int C_SEL_W = (C_WPC > 1) ? $clog2(C_WPC) : 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        wr_en,
    input  logic [3:0]                  wr_coeff,
    input  logic [C_SEL_W-1:0]          wr_slice,
    input  logic [BUS_BITS-1:0]         wr_data,
    output logic [NUM_COEFFS*WIDTH-1:0] bank_d
);

    logic [NUM_COEFFS*WIDTH-1:0] r_bank;

    // bank_d is the bank as it will look after this edge, so a commit can
    // capture the final word together with the rest of the frame.
    for (genvar c = 0; c < NUM_COEFFS; c++) begin : g_coeff
        for (genvar s = 0; s < C_WPC; s++) begin : g_slice
            localparam int C_LO = (c * C_WPC + s) * BUS_BITS;
            logic w_hit;
            assign w_hit = wr_en && (wr_coeff == 4'(c)) && (wr_slice == C_SEL_W'(s));
            assign bank_d[C_LO +: BUS_BITS] = w_hit ? wr_data : r_bank[C_LO +: BUS_BITS];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_bank <= '0;
        end else begin
            r_bank <= bank_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/register.sv
`default_nettype none
// ============================================================================
// Module   : register
// Brief    : Generic enabled register with synchronous active-high reset.
// Revision : 1.0
// ============================================================================
module register #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fnn_coeff_loader.sv
`default_nettype none
// ============================================================================
// Module   : fnn_coeff_loader
// Brief    : Serial coefficient loader; assembles a frame, commits atomically.
// Revision : 1.0
// ============================================================================
module fnn_coeff_loader
    import fnn_pkg::*;
#(
    parameter int WIDTH    = 64,
    parameter int BUS_BITS = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                word_valid,
    input  logic                word_first,
    input  logic [BUS_BITS-1:0] word_data,
    output logic                word_ready,
    output logic [WIDTH-1:0]    b0,
    output logic [WIDTH-1:0]    b1,
    output logic [WIDTH-1:0]    b2,
    output logic [WIDTH-1:0]    b3,
    output logic [WIDTH-1:0]    b4,
    output logic [WIDTH-1:0]    b5,
    output logic [WIDTH-1:0]    b6,
    output logic [WIDTH-1:0]    a3,
    output logic [WIDTH-1:0]    a6,
    output logic                coefficients_ready,
    output logic                frame_err
);

    localparam int C_WPC         = WIDTH / BUS_BITS;
    localparam int C_FRAME_WORDS = NUM_COEFFS * C_WPC;
    localparam int C_CNT_W       = $clog2(C_FRAME_WORDS);
    localparam int C_SEL_W       = (C_WPC > 1) ? $clog2(C_WPC) : 1;
    localparam logic [C_CNT_W-1:0] C_LAST       = C_CNT_W'(C_FRAME_WORDS - 1);
    localparam logic [C_SEL_W-1:0] C_SLICE_LAST = C_SEL_W'(C_WPC - 1);

    loader_state_e               r_state;
    logic [C_CNT_W-1:0]          r_wcnt;
    logic [3:0]                  r_cidx;
    logic [C_SEL_W-1:0]          r_sidx;
    logic                        r_have_set;
    logic                        r_coef_rdy;
    logic                        r_frame_err;

    logic                        w_accept;
    logic                        w_write;
    logic                        w_commit;
    logic                        w_slice_wrap;
    logic [3:0]                  w_cidx;
    logic [C_SEL_W-1:0]          w_sidx;
    logic [NUM_COEFFS*WIDTH-1:0] w_shadow_d;
    logic [NUM_COEFFS*WIDTH-1:0] w_active_q;

    assign word_ready = (r_state != ST_SWAP) && !reset;
    assign w_accept   = word_valid && word_ready;
    assign w_write    = w_accept && (word_first || (r_state == ST_FILL));
    assign w_commit   = w_accept && !word_first && (r_state == ST_FILL) && (r_wcnt == C_LAST);

    // Coefficient/slice position tracked alongside wcnt to avoid a divider.
    assign w_cidx       = word_first ? 4'd0 : r_cidx;
    assign w_sidx       = word_first ? '0 : r_sidx;
    assign w_slice_wrap = (w_sidx == C_SLICE_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_wcnt      <= '0;
            r_cidx      <= '0;
            r_sidx      <= '0;
            r_have_set  <= 1'b0;
            r_coef_rdy  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= w_accept && (word_first ? (r_state == ST_FILL)
                                                   : (r_state == ST_IDLE));
            case (r_state)
                ST_IDLE: begin
                    if (w_write) begin
                        r_state <= ST_FILL;
                        r_wcnt  <= C_CNT_W'(1);
                        r_sidx  <= w_slice_wrap ? '0 : w_sidx + C_SEL_W'(1);
                        r_cidx  <= w_slice_wrap ? w_cidx + 4'd1 : w_cidx;
                    end
                end
                ST_FILL: begin
                    if (w_commit) begin
                        r_state    <= ST_SWAP;
                        r_wcnt     <= '0;
                        r_cidx     <= '0;
                        r_sidx     <= '0;
                        r_have_set <= 1'b1;
                        r_coef_rdy <= 1'b0;
                    end else if (w_accept) begin
                        r_wcnt <= word_first ? C_CNT_W'(1) : r_wcnt + C_CNT_W'(1);
                        r_sidx <= w_slice_wrap ? '0 : w_sidx + C_SEL_W'(1);
                        r_cidx <= w_slice_wrap ? w_cidx + 4'd1 : w_cidx;
                    end
                end
                ST_SWAP: begin
                    r_state    <= ST_IDLE;
                    r_coef_rdy <= r_have_set;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    coeff_bank #(
        .WIDTH    (WIDTH),
        .BUS_BITS (BUS_BITS)
    ) u_shadow (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (w_write),
        .wr_coeff (w_cidx),
        .wr_slice (w_sidx),
        .wr_data  (word_data),
        .bank_d   (w_shadow_d)
    );

    register #(
        .W (NUM_COEFFS * WIDTH)
    ) u_active (
        .clk   (clk),
        .reset (reset),
        .en    (w_commit),
        .d     (w_shadow_d),
        .q     (w_active_q)
    );

    assign b0 = w_active_q[int'(B0)*WIDTH +: WIDTH];
    assign b1 = w_active_q[int'(B1)*WIDTH +: WIDTH];
    assign b2 = w_active_q[int'(B2)*WIDTH +: WIDTH];
    assign b3 = w_active_q[int'(B3)*WIDTH +: WIDTH];
    assign b4 = w_active_q[int'(B4)*WIDTH +: WIDTH];
    assign b5 = w_active_q[int'(B5)*WIDTH +: WIDTH];
    assign b6 = w_active_q[int'(B6)*WIDTH +: WIDTH];
    assign a3 = w_active_q[int'(A3)*WIDTH +: WIDTH];
    assign a6 = w_active_q[int'(A6)*WIDTH +: WIDTH];

    assign coefficients_ready = r_coef_rdy;
    assign frame_err          = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_fnn_coeff_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_fnn_coeff_loader
// Brief    : Scoreboard bench for fnn_coeff_loader at BUS_BITS=16 and 32.
// Revision : 1.0
// ============================================================================
module tb_fnn_coeff_loader;

    localparam int W = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          v16, f16, rdy16, cr16, fe16;
    logic [15:0]   d16;
    logic [W-1:0]  o16 [9];
    logic          v32, f32, rdy32, cr32, fe32;
    logic [31:0]   d32;
    logic [W-1:0]  o32 [9];
    logic [9*W-1:0] act16, act32;

    assign act16 = {o16[8], o16[7], o16[6], o16[5], o16[4], o16[3], o16[2], o16[1], o16[0]};
    assign act32 = {o32[8], o32[7], o32[6], o32[5], o32[4], o32[3], o32[2], o32[1], o32[0]};

    fnn_coeff_loader #(.WIDTH(W), .BUS_BITS(16)) dut16 (
        .clk(clk), .reset(reset), .word_valid(v16), .word_first(f16), .word_data(d16),
        .word_ready(rdy16), .b0(o16[0]), .b1(o16[1]), .b2(o16[2]), .b3(o16[3]),
        .b4(o16[4]), .b5(o16[5]), .b6(o16[6]), .a3(o16[7]), .a6(o16[8]),
        .coefficients_ready(cr16), .frame_err(fe16)
    );

    fnn_coeff_loader #(.WIDTH(W), .BUS_BITS(32)) dut32 (
        .clk(clk), .reset(reset), .word_valid(v32), .word_first(f32), .word_data(d32),
        .word_ready(rdy32), .b0(o32[0]), .b1(o32[1]), .b2(o32[2]), .b3(o32[3]),
        .b4(o32[4]), .b5(o32[5]), .b6(o32[6]), .a3(o32[7]), .a6(o32[8]),
        .coefficients_ready(cr32), .frame_err(fe32)
    );

    int total = 0;
    int bad   = 0;

    logic [9*W-1:0] q16 [$];
    logic [9*W-1:0] q32 [$];
    logic [9*W-1:0] held [2];
    logic           prev_rdy [2];
    logic           prev_err [2];
    int             err_seen [2];
    bit             mon_on = 1'b0;

    task automatic check_vec(input string name, input logic [9*W-1:0] act, input logic [9*W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    function automatic logic [9*W-1:0] pack_set(input logic [W-1:0] base, input logic [W-1:0] step);
        logic [9*W-1:0] p;
        p = '0;
        for (int k = 0; k < 9; k++) p[k*W +: W] = base + W'(k) * step;
        return p;
    endfunction

    function automatic logic get_rdy(input bit s);
        return s ? rdy32 : rdy16;
    endfunction

    function automatic logic get_cr(input bit s);
        return s ? cr32 : cr16;
    endfunction

    function automatic logic [9*W-1:0] get_act(input bit s);
        return s ? act32 : act16;
    endfunction

    task automatic drive(input bit s, input logic v, input logic f, input logic [31:0] d);
        if (s) begin
            v32 = v; f32 = f; d32 = d;
        end else begin
            v16 = v; f16 = f; d16 = d[15:0];
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the word is taken.
    task automatic send_word(input bit s, input logic first, input logic [31:0] data);
        int   n;
        logic r;
        n = 0;
        drive(s, 1'b1, first, data);
        do begin
            @(negedge clk);
            r = get_rdy(s);
            @(posedge clk);
            n++;
        end while (!r && n < 50);
        if (!r) begin
            total++;
            bad++;
            $display("FAIL word_accept_timeout: got ready=0 want ready=1 within 50 cycles");
        end
        #1 drive(s, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic send_words(input bit s, input logic [W-1:0] base, input logic [W-1:0] step,
                              input int n, input int maxgap);
        int             wpc, bb;
        logic [W-1:0]   c, sh;
        wpc = s ? 2 : 4;
        bb  = s ? 32 : 16;
        for (int w = 0; w < n; w++) begin
            if (maxgap > 0) begin
                repeat ($urandom_range(0, maxgap)) @(posedge clk);
                #1;
            end
            c  = base + W'(w / wpc) * step;
            sh = c >> ((w % wpc) * bb);
            send_word(s, (w == 0), sh[31:0]);
        end
    endtask

    task automatic send_frame(input bit s, input logic [W-1:0] base, input logic [W-1:0] step,
                              input int maxgap);
        logic [9*W-1:0] e;
        e = pack_set(base, step);
        if (s) q32.push_back(e); else q16.push_back(e);
        send_words(s, base, step, s ? 18 : 36, maxgap);
        @(negedge clk);
        check_bit("swap_coef_ready_low", get_cr(s), 1'b0);
        check_bit("swap_word_ready_low", get_rdy(s), 1'b0);
        check_vec("swap_new_outputs", get_act(s), e);
        @(negedge clk);
        check_bit("post_swap_coef_ready", get_cr(s), 1'b1);
        check_bit("post_swap_word_ready", get_rdy(s), 1'b1);
        @(posedge clk);
        #1;
    endtask

    task automatic mon(input bit s);
        logic           r, e;
        logic [9*W-1:0] a, x;
        r = get_cr(s);
        e = s ? fe32 : fe16;
        a = get_act(s);
        if (r === 1'b1 && prev_rdy[s] !== 1'b1) begin
            if ((s ? q32.size() : q16.size()) == 0) begin
                total++;
                bad++;
                $display("FAIL sb_commit: got unexpected commit want none (inst %0d)", s);
            end else begin
                if (s) x = q32.pop_front(); else x = q16.pop_front();
                held[s] = x;
                check_vec("sb_commit", a, x);
            end
        end else if (r === 1'b1) begin
            check_vec("hold_active_set", a, held[s]);
        end
        if (e === 1'b1) begin
            err_seen[s]++;
            if (prev_err[s] === 1'b1) check_bit("frame_err_width", prev_err[s], 1'b0);
        end
        prev_rdy[s] = r;
        prev_err[s] = e;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (mon_on) begin
                mon(1'b0);
                mon(1'b1);
            end
        end
    end

    initial begin
        logic [9*W-1:0] set_d;
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 2; i++) begin
            prev_rdy[i] = 1'b0; prev_err[i] = 1'b0; err_seen[i] = 0; held[i] = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_bit("reset_word_ready_low", rdy16, 1'b0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_vec("reset_outputs16", act16, '0);
        check_vec("reset_outputs32", act32, '0);
        check_bit("reset_coef_ready", cr16, 1'b0);
        check_bit("reset_frame_err", fe16, 1'b0);
        check_bit("after_reset_word_ready", rdy16, 1'b1);
        mon_on = 1'b1;
        @(posedge clk);
        #1;

        // Set A, no stalls
        send_frame(1'b0, 64'h0101_0101_0101_0100, 64'h1, 0);
        check_vec("setA_b0", {512'h0, o16[0]}, {512'h0, 64'h0101_0101_0101_0100});
        check_vec("setA_a6", {512'h0, o16[8]}, {512'h0, 64'h0101_0101_0101_0108});

        // Set B over active A, random valid gaps
        send_frame(1'b0, 64'hB0B0_0000_1234_0000, 64'h0000_0001_0000_0011, 3);

        // Abandoned 10-word frame, then full frame D
        send_words(1'b0, 64'hCCCC_CCCC_CCCC_CC00, 64'h1, 10, 0);
        send_frame(1'b0, 64'hD00D_5555_AAAA_0000, 64'h0100_0000_0000_0001, 0);
        check_int("abort_frame_err_count", err_seen[0], 1);
        set_d = pack_set(64'hD00D_5555_AAAA_0000, 64'h0100_0000_0000_0001);

        // Stray non-first word in IDLE
        send_word(1'b0, 1'b0, 32'h0000_DEAD);
        repeat (2) @(posedge clk);
        #1;
        check_int("idle_stray_frame_err_count", err_seen[0], 2);
        check_bit("idle_stray_coef_ready", cr16, 1'b1);
        check_bit("idle_stray_word_ready", rdy16, 1'b1);
        check_vec("idle_stray_outputs", act16, set_d);

        // Reset at word 20 of a reload; word 20 collides with reset
        send_words(1'b0, 64'hEEEE_0000_EEEE_0000, 64'h1, 20, 0);
        drive(1'b0, 1'b1, 1'b0, 32'h0000_EEEE);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        check_vec("midfill_reset_outputs", act16, '0);
        check_bit("midfill_reset_coef_ready", cr16, 1'b0);
        check_bit("midfill_reset_frame_err", fe16, 1'b0);
        check_bit("midfill_reset_word_ready", rdy16, 1'b1);
        @(posedge clk);
        #1;
        send_frame(1'b0, 64'hF1F2_F3F4_F5F6_F700, 64'h0001_0000_0000_0001, 0);
        check_int("frame_err_total16", err_seen[0], 2);

        // 32-bit bus instance: 18 words per frame
        send_frame(1'b1, 64'h0101_0101_0101_0100, 64'h1, 0);
        check_vec("bus32_b0", {512'h0, o32[0]}, {512'h0, 64'h0101_0101_0101_0100});
        check_vec("bus32_a6", {512'h0, o32[8]}, {512'h0, 64'h0101_0101_0101_0108});
        send_frame(1'b1, 64'h9876_5432_1000_0000, 64'h0000_0010_0000_0003, 2);

        repeat (3) @(negedge clk);
        check_int("sb_empty16", q16.size(), 0);
        check_int("sb_empty32", q32.size(), 0);
        check_int("frame_err_total32", err_seen[1], 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish want finish before 200000");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/fnn_coeff_loader.md
# fnn_coeff_loader

Serial coefficient loader that sits directly upstream of the lookahead IIR filter. It receives a frame of nine fixed-point coefficients over a narrow valid/ready word bus and assembles them in a shadow bank. It commits the complete set atomically to the filter's coefficient inputs, then drives `coefficients_ready`. On every commit, `coefficients_ready` drops for exactly one cycle, so the filter flushes its pipeline before running on the new set.

## Interface
- `WIDTH`, 64, coefficient width in bits (WHOLE_BITS+FRAC_BITS of the filter); must be a multiple of `BUS_BITS`
- `BUS_BITS`, 16, word-bus width
- `clk`  in  1  sole clock, rising edge
- `reset`  in  1  synchronous, active-high; one clock, reset is synchronous and active-high
- `word_valid`  in  1  upstream word present
- `word_first`  in  1  qualifies `word_data` as word 0 of a frame
- `word_data`  in  BUS_BITS  coefficient word
- `word_ready`  out  1  loader accepts a word this cycle
- `b0`..`b6`, `a3`, `a6`  out  WIDTH each  active coefficient set, to filter
- `coefficients_ready`  out  1  active set valid; low forces filter reset
- `frame_err`  out  1  one-cycle pulse on a protocol error

## Operation
- Frame layout:
  - `WPC = WIDTH/BUS_BITS` words per coefficient; `9*WPC` words per frame (36 at defaults).
  - Coefficient order is b0,b1,b2,b3,b4,b5,b6,a3,a6.
  - Within a coefficient, words arrive least-significant first. Word index w writes shadow coefficient `w/WPC`, bits `[(w%WPC)*BUS_BITS +: BUS_BITS]`.
- A word is accepted on any cycle with `word_valid && word_ready`.
- States:
  - IDLE: waiting for a frame.
  - FILL: frame in progress; word counter `wcnt` holds 1..9*WPC-1.
  - SWAP: one-cycle commit.
- A flag `have_set` records whether an active set exists.
- Transitions:
  - IDLE, accepted word with `word_first`=1: write word 0, `wcnt`<=1, go to FILL.
  - IDLE, accepted word with `word_first`=0: discard the word, pulse `frame_err`, stay in IDLE.
  - FILL, accepted word with `word_first`=0: write word `wcnt`, `wcnt`++.
  - FILL, accepted word with `word_first`=1: abandon the partial frame, pulse `frame_err`, treat the word as word 0 (`wcnt`<=1), stay in FILL.
  - FILL, accepted word at index 9*WPC-1: copy all nine shadow coefficients (including this word) to the active outputs on that same edge, set `have_set`, go to SWAP.
  - SWAP: go to IDLE unconditionally.
- `word_ready` = (state != SWAP) && !reset.
- `coefficients_ready` = `have_set` && (state != SWAP).
  - A reload that starts while a set is active keeps the old set and keeps `coefficients_ready` high until the commit.
- The active bank changes only on the commit edge, never piecewise.
- Shadow contents of an abandoned frame are irrelevant; every committed word position is rewritten by the new frame.

## Timing
- Reset values:
  - state IDLE, `wcnt`=0, `have_set`=0.
  - All coefficient outputs 0, `coefficients_ready`=0, `frame_err`=0.
  - `word_ready`=0 while `reset` is high, 1 on the first cycle after.
- Throughput: one word per cycle in IDLE and FILL, with no bubbles.
- Commit latency: last word accepted in cycle N.
  - Cycle N+1: new coefficients on the outputs, state SWAP, `coefficients_ready`=0, `word_ready`=0.
  - Cycle N+2: `coefficients_ready`=1 and state IDLE, ready for the next frame.
- `frame_err` is registered: it is high in the cycle after the offending acceptance, for exactly one cycle.
- `word_valid`=0 mid-frame: hold state and `wcnt` indefinitely; there is no timeout.
- Reset mid-FILL or mid-SWAP: everything returns to its reset values, including the active set; `coefficients_ready` is 0 on the next cycle.
- `reset` and an accepted word in the same cycle: `reset` wins and the word is lost.

## Structure
- Shared package `fnn_pkg`:
  - `NUM_COEFFS`=9.
  - Enum `coeff_idx_e` {B0..B6,A3,A6} defining frame order.
  - State enum `loader_state_e`.
- Sub-module `coeff_bank`: nine WIDTH-bit registers with a per-slice write enable (shadow); instantiated once.
- The active bank is built from the existing `register` block with `en` = commit.

## Test plan
- Load 36 words, coefficient k = 64'h0101_0101_0101_0100+k, without stalls:
  - b0=...0100, a6=...0108.
  - `coefficients_ready` rises exactly 2 cycles after the last word.
  - `coefficients_ready` is 0 for one cycle during SWAP.
- With set A active, stream set B with random `word_valid` gaps:
  - Outputs hold A and `coefficients_ready` stays 1 until commit.
  - Then a 1-cycle low, then B.
- Send 10 words, then a new `word_first` frame of 36:
  - `frame_err` pulses once.
  - The committed set equals the second frame only.
- Send a word with `word_first`=0 in IDLE:
  - `frame_err` pulses.
  - No state change; outputs unchanged.
- Assert `reset` at word 20 of a reload over an active set:
  - All outputs 0 and `coefficients_ready`=0 next cycle.
  - A fresh 36-word frame then commits normally.
- Parameter sweep BUS_BITS=32 (18 words/frame):
  - Word order and commit timing as above.
